// File: rtl/fm_voice_pkg.sv
// Shared types, routing table and arithmetic helpers for the TDM FM voice.
package fm_voice_pkg;

  localparam int ALG_ENTRIES = 8;
  localparam int MAX_OPS     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PHASE,
    S_LOOKUP,
    S_SCALE,
    S_ACCUM
  } fm_state_e;

  // mod_mask[k][j] set: op j modulates op k (only j<k is honoured)
  typedef struct packed {
    logic [MAX_OPS-1:0][7:0] mod_mask;
    logic [7:0]              carrier_mask;
  } alg_entry_t;

  localparam alg_entry_t ALGORITHM_TABLE [ALG_ENTRIES] = '{
    '{mod_mask: 64'h0000_0000_0402_0100, carrier_mask: 8'h08},  // 0->1->2->3
    '{mod_mask: 64'h0000_0000_0403_0000, carrier_mask: 8'h08},  // (0+1)->2->3
    '{mod_mask: 64'h0000_0000_0400_0100, carrier_mask: 8'h0A},  // 0->1, 2->3
    '{mod_mask: 64'h0000_0000_0101_0100, carrier_mask: 8'h0E},  // 0->{1,2,3}
    '{mod_mask: 64'h0000_0000_0000_0100, carrier_mask: 8'h0E},  // 0->1, 2, 3
    '{mod_mask: 64'h0000_0000_0002_0100, carrier_mask: 8'h0C},  // 0->1->2, 3
    '{mod_mask: 64'h0000_0000_0700_0000, carrier_mask: 8'h08},  // (0+1+2)->3
    '{mod_mask: 64'h0000_0000_0000_0000, carrier_mask: 8'hFF}   // additive
  };

  // Bhaskara approximation of sin over the first quadrant; u in 0..2^(addr_bits-2).
  function automatic longint quarter_sine_mag(input int u, input int addr_bits, input int sw);
    longint h, mx, prod;
    h    = longint'(1) << (addr_bits - 1);
    mx   = (longint'(1) << (sw - 1)) - 1;
    prod = longint'(u) * (h - longint'(u));
    return (mx * 4 * prod) / ((5 * h * h) / 4 - prod);
  endfunction

  // Symmetric clamp to +/-(2^(w-1)-1).
  function automatic longint sat_signed(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << (w - 1)) - 1;
    if (v > mx)  return mx;
    if (v < -mx) return -mx;
    return v;
  endfunction

endpackage

// File: rtl/fm_voice_tdm_sine_lut.sv
// Quarter-wave sine ROM with registered output; symmetry rebuilds the full period.
module sine_lut
  import fm_voice_pkg::*;
#(
  parameter int SINE_ADDR_WIDTH = 10,
  parameter int SAMPLE_WIDTH    = 24
) (
  input  logic                           i_Clock,
  input  logic                           i_Reset,
  input  logic [SINE_ADDR_WIDTH-1:0]     i_Addr,
  output logic signed [SAMPLE_WIDTH-1:0] o_Sine
);

  localparam int QW = SINE_ADDR_WIDTH - 2;
  localparam int QN = 2 ** QW;
  localparam logic [SAMPLE_WIDTH-2:0] FULL = '1;

  logic [SAMPLE_WIDTH-2:0] rom [QN];

  for (genvar g = 0; g < QN; g++) begin : g_rom
    assign rom[g] = (SAMPLE_WIDTH-1)'(quarter_sine_mag(g, SINE_ADDR_WIDTH, SAMPLE_WIDTH));
  end

  logic [QW-1:0]                  idx, midx;
  logic [SAMPLE_WIDTH-2:0]        mag;
  logic signed [SAMPLE_WIDTH-1:0] sine_d, sine_q;

  // Mirrored quadrants at offset 0 land on the peak, which the table does not hold.
  always_comb begin
    idx    = i_Addr[QW-1:0];
    midx   = i_Addr[QW] ? -idx : idx;
    mag    = (i_Addr[QW] && idx == '0) ? FULL : rom[midx];
    sine_d = i_Addr[QW+1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) sine_q <= '0;
    else         sine_q <= sine_d;
  end

  assign o_Sine = sine_q;

endmodule

// File: rtl/fm_voice_tdm.sv
// N-operator FM voice: one shared operator datapath time-multiplexed over all
// operators per sample, with table routing, op0 feedback and saturating mix.
module fm_voice_tdm
  import fm_voice_pkg::*;
#(
  parameter int NUM_OPERATORS   = 4,
  parameter int PHASE_WIDTH     = 24,
  parameter int SAMPLE_WIDTH    = 24,
  parameter int SINE_ADDR_WIDTH = 10,
  parameter int NUM_ALGORITHMS  = 8
) (
  input  logic                                   i_Clock,
  input  logic                                   i_Reset,
  input  logic                                   i_SampleStrobe,
  input  logic                                   i_KeyOn,
  input  logic [$clog2(NUM_ALGORITHMS)-1:0]      i_Algorithm,
  input  logic [2:0]                             i_Feedback,
  input  logic [NUM_OPERATORS*PHASE_WIDTH-1:0]   i_PhaseStep,
  input  logic [NUM_OPERATORS*8-1:0]             i_Level,
  output logic                                   o_Busy,
  output logic                                   o_SampleValid,
  output logic [SAMPLE_WIDTH-1:0]                o_Sample,
  output logic                                   o_Overrun
);

  localparam int N    = NUM_OPERATORS;
  localparam int PW   = PHASE_WIDTH;
  localparam int SW   = SAMPLE_WIDTH;
  localparam int AW   = $clog2(NUM_ALGORITHMS);
  localparam int OPW  = $clog2(NUM_OPERATORS);
  localparam int SUMW = SW + 3;

  logic [N-1:0][PW-1:0] step_w;
  logic [N-1:0][7:0]    lvl_w;
  assign step_w = i_PhaseStep;
  assign lvl_w  = i_Level;

  fm_state_e            state_q;
  logic [OPW-1:0]       op_q;
  logic                 key_q;
  logic [AW-1:0]        alg_q;
  logic [2:0]           fb_q;
  logic [N-1:0][PW-1:0] acc_q;
  logic [N-1:0][SW-1:0] out_q;
  logic [SW-1:0]        prev0_q;
  logic [PW-1:0]        phase_q;
  logic signed [SUMW-1:0] sum_q;
  logic                 accum2_q;
  logic                 busy_q, valid_q, overrun_q;
  logic [SW-1:0]        sample_q;

  logic signed [SUMW-1:0] modsum, csum_d;
  logic [PW-1:0]          phase_d;
  logic signed [SW-1:0]   sine;
  logic signed [SW+8:0]   prod;
  logic [SW-1:0]          scaled_d, sample_d;

  sine_lut #(
    .SINE_ADDR_WIDTH(SINE_ADDR_WIDTH),
    .SAMPLE_WIDTH   (SAMPLE_WIDTH)
  ) u_sine (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Addr (phase_q[PW-1 -: SINE_ADDR_WIDTH]),
    .o_Sine (sine)
  );

  always_comb begin
    modsum = '0;
    if (op_q == '0) begin
      if (fb_q != 3'd0)
        modsum = SUMW'($signed(prev0_q) >>> (4'd8 - {1'b0, fb_q}));
    end else begin
      for (int j = 0; j < N; j++)
        if (j < int'(op_q) && ALGORITHM_TABLE[alg_q].mod_mask[op_q][j])
          modsum = modsum + SUMW'($signed(out_q[j]));
    end
    phase_d = acc_q[op_q] + PW'(modsum);

    prod     = sine * $signed({1'b0, lvl_w[op_q]});
    scaled_d = SW'(prod >>> 8);

    csum_d = '0;
    for (int k = 0; k < N; k++)
      if (ALGORITHM_TABLE[alg_q].carrier_mask[k])
        csum_d = csum_d + SUMW'($signed(out_q[k]));

    sample_d = SW'(sat_signed(longint'(sum_q), SW));
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      key_q     <= 1'b0;
      alg_q     <= '0;
      fb_q      <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      prev0_q   <= '0;
      phase_q   <= '0;
      sum_q     <= '0;
      accum2_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sample_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      if (i_SampleStrobe && state_q != S_IDLE) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (i_SampleStrobe) begin
            key_q   <= i_KeyOn;
            alg_q   <= i_Algorithm;
            fb_q    <= i_Feedback;
            op_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_PHASE;
          end
        end
        S_PHASE: begin
          phase_q       <= phase_d;
          acc_q[op_q]   <= key_q ? acc_q[op_q] + step_w[op_q] : '0;
          state_q       <= S_LOOKUP;
        end
        S_LOOKUP: state_q <= S_SCALE;
        S_SCALE: begin
          out_q[op_q] <= scaled_d;
          if (op_q == OPW'(N - 1)) begin
            accum2_q <= 1'b0;
            state_q  <= S_ACCUM;
          end else begin
            op_q    <= op_q + 1'b1;
            state_q <= S_PHASE;
          end
        end
        S_ACCUM: begin
          // Carrier sum and clamp are split over two cycles to keep them off one path.
          if (!accum2_q) begin
            sum_q    <= csum_d;
            accum2_q <= 1'b1;
          end else begin
            sample_q <= key_q ? sample_d : '0;
            prev0_q  <= key_q ? out_q[0] : '0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Busy        = busy_q;
  assign o_SampleValid = valid_q;
  assign o_Sample      = sample_q;
  assign o_Overrun     = overrun_q;

endmodule

// File: tb/tb_fm_voice_tdm.sv
// Directed checks of the TDM FM voice: latency, routing, saturation, feedback,
// overrun and mid-sample reset.
module tb_fm_voice_tdm;

  localparam int N   = 4;
  localparam int PW  = 24;
  localparam int SW  = 24;
  localparam int LAT = 3 * N + 2;
  localparam logic [23:0] Q1 = 24'h40_0000;
  localparam logic [23:0] Q3 = 24'hC0_0000;
  localparam longint POS_PK = 8355839;
  localparam longint NEG_PK = -8355840;
  localparam longint SATV   = 8388607;

  logic              i_Clock = 1'b0;
  logic              i_Reset;
  logic              i_SampleStrobe;
  logic              i_KeyOn;
  logic [2:0]        i_Algorithm;
  logic [2:0]        i_Feedback;
  logic [N*PW-1:0]   i_PhaseStep;
  logic [N*8-1:0]    i_Level;
  logic              o_Busy;
  logic              o_SampleValid;
  logic [SW-1:0]     o_Sample;
  logic              o_Overrun;

  int checks = 0;
  int errors = 0;

  fm_voice_tdm dut (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_SampleStrobe(i_SampleStrobe),
    .i_KeyOn       (i_KeyOn),
    .i_Algorithm   (i_Algorithm),
    .i_Feedback    (i_Feedback),
    .i_PhaseStep   (i_PhaseStep),
    .i_Level       (i_Level),
    .o_Busy        (o_Busy),
    .o_SampleValid (o_SampleValid),
    .o_Sample      (o_Sample),
    .o_Overrun     (o_Overrun)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    i_SampleStrobe = 1'b0;
    tick();
    i_Reset = 1'b0;
  endtask

  task automatic set_op(input int k, input logic [PW-1:0] step, input logic [7:0] lvl);
    i_PhaseStep[k*PW +: PW] = step;
    i_Level[k*8 +: 8]       = lvl;
  endtask

  task automatic start(input logic key, input logic [2:0] alg, input logic [2:0] fb);
    i_KeyOn = key;
    i_Algorithm = alg;
    i_Feedback = fb;
    i_SampleStrobe = 1'b1;
    tick();
    i_SampleStrobe = 1'b0;
  endtask

  // One sample with latency and busy checks; returns the sample value.
  task automatic run_sample(input string tag, input logic key, input logic [2:0] alg,
                            input logic [2:0] fb, output logic signed [SW-1:0] s);
    int   lat;
    logic busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    start(key, alg, fb);
    for (int e = 1; e <= 3 * LAT && lat < 0; e++) begin
      tick();
      if (o_SampleValid) lat = e;
      else if (!o_Busy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_busy_held"}, busy_ok, 1);
    chk({tag, "_busy_drop"}, o_Busy, 0);
    s = $signed(o_Sample);
  endtask

  task automatic run_expect(input string tag, input logic key, input logic [2:0] alg,
                            input logic [2:0] fb, input logic signed [63:0] exp);
    logic signed [SW-1:0] s;
    run_sample(tag, key, alg, fb, s);
    chk({tag, "_sample"}, s, exp);
  endtask

  logic signed [SW-1:0] s3;
  int vcnt, vedge;

  initial begin
    i_Reset = 1'b1;
    i_SampleStrobe = 1'b0;
    i_KeyOn = 1'b0;
    i_Algorithm = '0;
    i_Feedback = '0;
    i_PhaseStep = '0;
    i_Level = '0;
    tick(); tick();
    chk("rst_busy", o_Busy, 0);
    chk("rst_valid", o_SampleValid, 0);
    chk("rst_sample", $signed(o_Sample), 0);
    chk("rst_overrun", o_Overrun, 0);
    i_Reset = 1'b0;

    // Key off: full-length sequence, silent output.
    set_op(0, Q1, 8'd255);
    run_expect("keyoff", 1'b0, 3'd7, 3'd0, 0);
    chk("keyoff_overrun", o_Overrun, 0);

    // Single op0 carrier walking the four quadrant points.
    do_reset();
    i_PhaseStep = '0; i_Level = '0;
    set_op(0, Q1, 8'd255);
    run_expect("alg7_s1", 1'b1, 3'd7, 3'd0, 0);
    run_expect("alg7_s2", 1'b1, 3'd7, 3'd0, POS_PK);
    run_expect("alg7_s3", 1'b1, 3'd7, 3'd0, 0);
    run_expect("alg7_s4", 1'b1, 3'd7, 3'd0, NEG_PK);

    // Four carriers in phase: sum clamps both ways.
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, Q1, 8'd255);
    run_expect("sat_a_s1", 1'b1, 3'd7, 3'd0, 0);
    run_expect("sat_a_s2", 1'b1, 3'd7, 3'd0, SATV);
    run_expect("sat_a_s3", 1'b1, 3'd7, 3'd0, 0);
    run_expect("sat_a_s4", 1'b1, 3'd7, 3'd0, -SATV);
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, Q3, 8'd255);
    run_expect("sat_b_s1", 1'b1, 3'd7, 3'd0, 0);
    run_expect("sat_b_s2", 1'b1, 3'd7, 3'd0, -SATV);
    run_expect("sat_b_s3", 1'b1, 3'd7, 3'd0, 0);
    run_expect("sat_b_s4", 1'b1, 3'd7, 3'd0, SATV);

    // Strobe while busy: ignored, sticky overrun.
    do_reset();
    i_PhaseStep = '0; i_Level = '0;
    set_op(0, Q1, 8'd255);
    vcnt = 0; vedge = -1;
    start(1'b1, 3'd7, 3'd0);
    for (int e = 1; e <= 2 * LAT; e++) begin
      i_SampleStrobe = (e == 3);
      tick();
      if (o_SampleValid) begin vcnt++; vedge = e; end
    end
    i_SampleStrobe = 1'b0;
    chk("ovr_pulses", vcnt, 1);
    chk("ovr_edge", vedge, LAT);
    chk("ovr_flag", o_Overrun, 1);
    run_expect("ovr_next", 1'b1, 3'd7, 3'd0, POS_PK);
    chk("ovr_sticky", o_Overrun, 1);
    do_reset();
    chk("ovr_cleared", o_Overrun, 0);

    // Chain algorithm with silent modulators equals a lone carrier on op3.
    i_PhaseStep = '0; i_Level = '0;
    set_op(3, Q1, 8'd255);
    run_expect("alg0_s1", 1'b1, 3'd0, 3'd0, 0);
    run_expect("alg0_s2", 1'b1, 3'd0, 3'd0, POS_PK);
    run_expect("alg0_s3", 1'b1, 3'd0, 3'd0, 0);
    run_expect("alg0_s4", 1'b1, 3'd0, 3'd0, NEG_PK);

    // Maximum feedback bends op0's third sample away from the zero crossing.
    do_reset();
    i_PhaseStep = '0; i_Level = '0;
    set_op(0, Q1, 8'd255);
    run_expect("fb_s1", 1'b1, 3'd7, 3'd7, 0);
    run_expect("fb_s2", 1'b1, 3'd7, 3'd7, POS_PK);
    run_sample("fb_s3", 1'b1, 3'd7, 3'd7, s3);
    chk("fb_s3_nonzero", (s3 != 0), 1);
    chk("fb_s3_negative", (s3 < 0), 1);

    // Reset in the middle of a sample aborts it cleanly.
    do_reset();
    start(1'b1, 3'd7, 3'd0);
    for (int e = 1; e <= 5; e++) begin
      i_Reset = (e == 5);
      tick();
    end
    i_Reset = 1'b0;
    chk("abort_busy", o_Busy, 0);
    chk("abort_valid", o_SampleValid, 0);
    vcnt = 0;
    for (int e = 0; e < 2 * LAT; e++) begin
      tick();
      if (o_SampleValid) vcnt++;
    end
    chk("abort_no_pulse", vcnt, 0);
    run_expect("rerun_s1", 1'b1, 3'd7, 3'd0, 0);
    run_expect("rerun_s2", 1'b1, 3'd7, 3'd0, POS_PK);
    run_expect("rerun_s3", 1'b1, 3'd7, 3'd0, 0);
    run_expect("rerun_s4", 1'b1, 3'd7, 3'd0, NEG_PK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
